stage_pipe_buf: RTL and testbench
=================================

STAGE_PIPE_BUF -- requirements
Module: stage_pipe_buf

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, on ports clk and rst.
REQ-002 Parameter DATA_W, default 32: payload width in bits, >=1.
REQ-003 Parameter DEPTH, default 2: entry count; power of two, >=2.
REQ-004 Parameter FALLTHRU, default 0: 1 = zero-latency bypass when empty; 0 = fully registered.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst  input  1  synchronous active-high reset.
REQ-007 Port flush  input  1  synchronous discard of all held entries (pipeline redirect).
REQ-008 Port s_valid  input  1  upstream payload valid.
REQ-009 Port s_ready  output  1  buffer can accept this cycle.
REQ-010 Port s_data  input  DATA_W  upstream payload.
REQ-011 Port m_valid  output  1  downstream payload valid.
REQ-012 Port m_ready  input  1  downstream accepts.
REQ-013 Port m_data  output  DATA_W  downstream payload.
REQ-014 Port count  output  $clog2(DEPTH)+1  entries currently stored.

Function
REQ-015 The block SHALL define push = s_valid & s_ready and pop = m_valid & m_ready, both sampled at the rising clk edge.
REQ-016 s_ready SHALL be (count != DEPTH) & ~flush & ~rst, with no combinational dependence on m_ready.
REQ-017 With FALLTHRU=0, m_valid SHALL be (count != 0) & ~flush, and m_data SHALL be the oldest stored entry; the latency from push to m_valid is 1 cycle.
REQ-018 With FALLTHRU=1 and count==0, m_valid SHALL equal s_valid & ~flush and m_data SHALL equal s_data combinationally.
REQ-019 With FALLTHRU=1, count==0 and push & m_ready, the entry SHALL bypass and SHALL NOT be stored, so count stays 0.
REQ-020 With FALLTHRU=1 and count>0, behaviour SHALL be identical to FALLTHRU=0.
REQ-021 Entries SHALL be delivered in strict FIFO order, with no loss or duplication absent flush.
REQ-022 The write and read pointers SHALL each advance by 1 per stored push or pop, wrapping modulo DEPTH (DEPTH-1 -> 0).
REQ-023 count update: stored push only -> +1; pop of a stored entry only -> -1; both -> unchanged; neither -> unchanged.
REQ-024 When full, s_ready SHALL be 0; a simultaneous pop in that cycle SHALL NOT enable a push in the same cycle.
REQ-025 When count==DEPTH-1 and a push occurs without a pop, s_ready SHALL be 0 in the next cycle.
REQ-026 While m_valid=1 and m_ready=0, m_data SHALL remain stable; once asserted, m_valid SHALL NOT deassert before pop, except on flush or rst.
REQ-027 flush=1 SHALL take priority over push and pop: no entry is stored or popped in that cycle, the next cycle has count=0 and both pointers=0, and stored data is not cleared.
REQ-028 flush and rst asserted together SHALL behave as rst.
REQ-029 Storage SHALL be an array of DEPTH x DATA_W registers without reset; only control state is reset.

Reset
REQ-030 While rst=1, s_ready=0 and m_valid=0 (for both FALLTHRU values).
REQ-031 The cycle after rst is released, count=0, pointers=0, s_ready=1, and m_valid=0 (FALLTHRU=0) or m_valid=s_valid (FALLTHRU=1).
REQ-032 rst asserted mid-transfer SHALL discard all entries; no stale entry appears after release.

Verification
REQ-033 Basic transfer: DEPTH=2, FALLTHRU=0, push 0xA5A5_0001 with m_ready=1 -> m_valid=1, m_data=0xA5A5_0001 the next cycle, popped; count goes 0->1->0.
REQ-034 Fill and backpressure: DEPTH=4, m_ready=0, push 0x1..0x5 back-to-back -> s_ready=0 after the 4th push; count=4; 0x5 is held upstream. Then m_ready=1 -> outputs 0x1,0x2,0x3,0x4,0x5 in order.
REQ-035 Full plus simultaneous pop: DEPTH=2, full, m_ready=1, s_valid=1 -> pop only that cycle and count=1; the push succeeds the next cycle.
REQ-036 Flush: DEPTH=4 holding 3 entries, flush=1 with s_valid=1 and m_ready=1 -> no pop or push that cycle; the next cycle count=0, m_valid=0, s_ready=1.
REQ-037 Fallthrough: FALLTHRU=1, empty, s_valid=1, s_data=0xDEAD_BEEF, m_ready=1 -> m_valid=1 and m_data=0xDEAD_BEEF in the same cycle; count stays 0. Repeat with m_ready=0 -> count=1 and the data is held.
REQ-038 Wrap and reset: DEPTH=2, random valid/ready for 1000 cycles against a scoreboard -> order is preserved across pointer wrap; rst asserted mid-run -> s_ready=0 and m_valid=0 during reset, and the scoreboard is empty after release.

Source files
------------

// File: rtl/stage_pipe_buf.sv
// Elastic pipeline buffer between two valid/ready stages: a small FIFO with an
// optional zero-latency bypass when empty, plus a flush used for pipeline redirects.
module stage_pipe_buf #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2,
  parameter bit FALLTHRU = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wrPtr, rdPtr;
  logic              empty, full, bypass;
  logic              push, pop, wrEn, rdEn;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign bypass = FALLTHRU && empty;

  // s_ready looks only at occupancy, so a same-cycle pop never frees a slot.
  assign s_ready = ~full & ~flush & ~rst;
  assign m_valid = (bypass ? s_valid : ~empty) & ~flush & ~rst;
  assign m_data  = bypass ? s_data : mem[rdPtr];

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;
  // A bypassed beat is consumed directly and never touches storage.
  assign wrEn = push & ~(bypass & m_ready);
  assign rdEn = pop & ~bypass;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + PW'(1);
      if (rdEn) rdPtr <= rdPtr + PW'(1);
      case ({wrEn, rdEn})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage is deliberately not reset; control state alone defines validity.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= s_data;
  end
endmodule

// File: tb/tb_stage_pipe_buf.sv
// Directed bench for stage_pipe_buf: three instances cover DEPTH=2/4 registered
// and DEPTH=2 fallthrough configurations.
module tb_stage_pipe_buf;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  // A: DEPTH=2 FALLTHRU=0
  logic flA = 0, svA = 0, srA, mvA, mrA = 0;
  logic [31:0] sdA = '0, mdA;
  logic [1:0] cntA;
  // B: DEPTH=4 FALLTHRU=0
  logic flB = 0, svB = 0, srB, mvB, mrB = 0;
  logic [31:0] sdB = '0, mdB;
  logic [2:0] cntB;
  // F: DEPTH=2 FALLTHRU=1
  logic flF = 0, svF = 0, srF, mvF, mrF = 0;
  logic [31:0] sdF = '0, mdF;
  logic [1:0] cntF;

  stage_pipe_buf #(.DATA_W(32), .DEPTH(2), .FALLTHRU(1'b0)) uA (
    .clk(clk), .rst(rst), .flush(flA), .s_valid(svA), .s_ready(srA), .s_data(sdA),
    .m_valid(mvA), .m_ready(mrA), .m_data(mdA), .count(cntA));
  stage_pipe_buf #(.DATA_W(32), .DEPTH(4), .FALLTHRU(1'b0)) uB (
    .clk(clk), .rst(rst), .flush(flB), .s_valid(svB), .s_ready(srB), .s_data(sdB),
    .m_valid(mvB), .m_ready(mrB), .m_data(mdB), .count(cntB));
  stage_pipe_buf #(.DATA_W(32), .DEPTH(2), .FALLTHRU(1'b1)) uF (
    .clk(clk), .rst(rst), .flush(flF), .s_valid(svF), .s_ready(srF), .s_data(sdF),
    .m_valid(mvF), .m_ready(mrF), .m_data(mdF), .count(cntF));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; svA = 1; svB = 1; svF = 1; mrF = 1;
    tick; tick;
    #1;
    nVec++; if (srA !== 1'b0) begin nErr++; $display("FAIL rst_srA got=%b want=0", srA); end
    nVec++; if (mvA !== 1'b0) begin nErr++; $display("FAIL rst_mvA got=%b want=0", mvA); end
    nVec++; if (srB !== 1'b0) begin nErr++; $display("FAIL rst_srB got=%b want=0", srB); end
    nVec++; if (srF !== 1'b0) begin nErr++; $display("FAIL rst_srF got=%b want=0", srF); end
    nVec++; if (mvF !== 1'b0) begin nErr++; $display("FAIL rst_mvF got=%b want=0", mvF); end
    tick;
    rst = 0; svA = 0; svB = 0; sdF = 32'h0000_0F0F;
    #1;
    nVec++; if (cntA !== 2'd0) begin nErr++; $display("FAIL rel_cntA got=%0d want=0", cntA); end
    nVec++; if (srA !== 1'b1) begin nErr++; $display("FAIL rel_srA got=%b want=1", srA); end
    nVec++; if (mvA !== 1'b0) begin nErr++; $display("FAIL rel_mvA got=%b want=0", mvA); end
    nVec++; if (cntB !== 3'd0) begin nErr++; $display("FAIL rel_cntB got=%0d want=0", cntB); end
    nVec++; if (mvF !== 1'b1) begin nErr++; $display("FAIL rel_mvF got=%b want=1", mvF); end
    nVec++; if (mdF !== 32'h0000_0F0F) begin nErr++; $display("FAIL rel_mdF got=%h want=00000f0f", mdF); end
    tick;
    svF = 0; mrF = 0;
    #1;
    nVec++; if (cntF !== 2'd0) begin nErr++; $display("FAIL rel_bypass_cntF got=%0d want=0", cntF); end
  endtask

  task automatic test_basic;
    svA = 1; sdA = 32'hA5A5_0001; mrA = 1;
    #1;
    nVec++; if (mvA !== 1'b0) begin nErr++; $display("FAIL basic_mv0 got=%b want=0", mvA); end
    nVec++; if (srA !== 1'b1) begin nErr++; $display("FAIL basic_sr0 got=%b want=1", srA); end
    tick;
    svA = 0;
    #1;
    nVec++; if (cntA !== 2'd1) begin nErr++; $display("FAIL basic_cnt1 got=%0d want=1", cntA); end
    nVec++; if (mvA !== 1'b1) begin nErr++; $display("FAIL basic_mv1 got=%b want=1", mvA); end
    nVec++; if (mdA !== 32'hA5A5_0001) begin nErr++; $display("FAIL basic_md got=%h want=a5a50001", mdA); end
    tick;
    #1;
    nVec++; if (cntA !== 2'd0) begin nErr++; $display("FAIL basic_cnt2 got=%0d want=0", cntA); end
    nVec++; if (mvA !== 1'b0) begin nErr++; $display("FAIL basic_mv2 got=%b want=0", mvA); end
    mrA = 0;
  endtask

  task automatic test_fill;
    logic [31:0] got[$];
    logic acc;
    mrB = 0;
    for (int i = 1; i <= 5; i++) begin
      svB = 1; sdB = 32'(i);
      #1;
      nVec++;
      if (srB !== (i <= 4)) begin nErr++; $display("FAIL fill_sr%0d got=%b want=%b", i, srB, (i <= 4)); end
      if (i < 5) tick;
    end
    nVec++; if (cntB !== 3'd4) begin nErr++; $display("FAIL fill_cnt got=%0d want=4", cntB); end
    mrB = 1;
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      #1;
      if (mvB && mrB) got.push_back(mdB);
      acc = svB & srB;
      tick;
      if (acc) svB = 0;
    end
    nVec++; if (got.size() != 5) begin nErr++; $display("FAIL fill_drain_len got=%0d want=5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      nVec++;
      if (got[i] !== 32'(i + 1)) begin nErr++; $display("FAIL fill_order[%0d] got=%h want=%h", i, got[i], 32'(i + 1)); end
    end
    svB = 0; mrB = 0;
    tick;
  endtask

  task automatic test_full_pop;
    svA = 1; sdA = 32'h11; tick;
    sdA = 32'h22; tick;
    mrA = 1; sdA = 32'h33;
    #1;
    nVec++; if (cntA !== 2'd2) begin nErr++; $display("FAIL full_cnt got=%0d want=2", cntA); end
    nVec++; if (srA !== 1'b0) begin nErr++; $display("FAIL full_sr got=%b want=0", srA); end
    nVec++; if (mdA !== 32'h11) begin nErr++; $display("FAIL full_md got=%h want=11", mdA); end
    tick;
    #1;
    nVec++; if (cntA !== 2'd1) begin nErr++; $display("FAIL fullpop_cnt got=%0d want=1", cntA); end
    nVec++; if (srA !== 1'b1) begin nErr++; $display("FAIL fullpop_sr got=%b want=1", srA); end
    nVec++; if (mdA !== 32'h22) begin nErr++; $display("FAIL fullpop_md got=%h want=22", mdA); end
    tick;
    svA = 0;
    #1;
    nVec++; if (cntA !== 2'd1) begin nErr++; $display("FAIL fullpush_cnt got=%0d want=1", cntA); end
    nVec++; if (mdA !== 32'h33) begin nErr++; $display("FAIL fullpush_md got=%h want=33", mdA); end
    tick;
    mrA = 0;
    #1;
    nVec++; if (cntA !== 2'd0) begin nErr++; $display("FAIL fulldrain_cnt got=%0d want=0", cntA); end
  endtask

  task automatic test_flush;
    mrB = 0; svB = 1;
    for (int i = 0; i < 3; i++) begin sdB = 32'h31 + 32'(i); tick; end
    #1;
    nVec++; if (cntB !== 3'd3) begin nErr++; $display("FAIL flush_pre_cnt got=%0d want=3", cntB); end
    flB = 1; mrB = 1; sdB = 32'h77;
    #1;
    nVec++; if (srB !== 1'b0) begin nErr++; $display("FAIL flush_sr got=%b want=0", srB); end
    nVec++; if (mvB !== 1'b0) begin nErr++; $display("FAIL flush_mv got=%b want=0", mvB); end
    tick;
    flB = 0; svB = 0; mrB = 0;
    #1;
    nVec++; if (cntB !== 3'd0) begin nErr++; $display("FAIL flush_cnt got=%0d want=0", cntB); end
    nVec++; if (mvB !== 1'b0) begin nErr++; $display("FAIL flush_mv_after got=%b want=0", mvB); end
    nVec++; if (srB !== 1'b1) begin nErr++; $display("FAIL flush_sr_after got=%b want=1", srB); end
    tick;
  endtask

  task automatic test_fallthru;
    svF = 1; sdF = 32'hDEAD_BEEF; mrF = 1;
    #1;
    nVec++; if (mvF !== 1'b1) begin nErr++; $display("FAIL ft_mv got=%b want=1", mvF); end
    nVec++; if (mdF !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL ft_md got=%h want=deadbeef", mdF); end
    tick;
    svF = 0;
    #1;
    nVec++; if (cntF !== 2'd0) begin nErr++; $display("FAIL ft_cnt_bypass got=%0d want=0", cntF); end
    svF = 1; mrF = 0;
    #1;
    nVec++; if (mvF !== 1'b1) begin nErr++; $display("FAIL ft_mv_stall got=%b want=1", mvF); end
    tick;
    sdF = 32'h1234; mrF = 0;
    #1;
    nVec++; if (cntF !== 2'd1) begin nErr++; $display("FAIL ft_cnt_held got=%0d want=1", cntF); end
    nVec++; if (mdF !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL ft_md_held got=%h want=deadbeef", mdF); end
    tick;
    svF = 0;
    #1;
    nVec++; if (cntF !== 2'd2) begin nErr++; $display("FAIL ft_cnt_full got=%0d want=2", cntF); end
    nVec++; if (mdF !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL ft_md_stable got=%h want=deadbeef", mdF); end
    mrF = 1;
    tick;
    #1;
    nVec++; if (mdF !== 32'h1234) begin nErr++; $display("FAIL ft_md_second got=%h want=00001234", mdF); end
    tick;
    mrF = 0;
    #1;
    nVec++; if (cntF !== 2'd0) begin nErr++; $display("FAIL ft_cnt_end got=%0d want=0", cntF); end
  endtask

  task automatic test_random;
    logic [31:0] q[$];
    logic [31:0] exp;
    for (int c = 0; c < 1000; c++) begin
      rst = (c >= 500 && c < 503);
      svA = 1'($urandom_range(0, 1));
      sdA = $urandom;
      mrA = 1'($urandom_range(0, 1));
      #1;
      if (rst) begin
        nVec++;
        if (srA !== 1'b0 || mvA !== 1'b0) begin nErr++; $display("FAIL rnd_rst c=%0d sr=%b mv=%b want=0,0", c, srA, mvA); end
        q.delete();
      end else begin
        nVec++;
        if (cntA !== 2'(q.size())) begin nErr++; $display("FAIL rnd_cnt c=%0d got=%0d want=%0d", c, cntA, q.size()); end
        nVec++;
        if (mvA !== (q.size() != 0)) begin nErr++; $display("FAIL rnd_mv c=%0d got=%b want=%b", c, mvA, (q.size() != 0)); end
        if (mvA && mrA && q.size() != 0) begin
          exp = q.pop_front();
          nVec++;
          if (mdA !== exp) begin nErr++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, mdA, exp); end
        end
        if (svA && srA) q.push_back(sdA);
      end
      tick;
    end
    rst = 0; svA = 0; mrA = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_fill;
    test_full_pop;
    test_flush;
    test_fallthru;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
